// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared types for the two-requester SRAM RW port arbiter.
// Revision : 1.0
// ============================================================================
package sram_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef logic req_id_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   typedef struct packed {
      logic    valid;
      logic    rd;
      req_id_t id;
   } pipe_entry_t;

   function automatic req_id_t other_req(input req_id_t id);
      return ~id;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rw_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant with a registered priority pointer.
// Revision : 1.0
// ============================================================================
module rr_arb2
   import sram_arb_pkg::*;
(
   input  logic               clk0,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   output logic [NUM_REQ-1:0] grant
);

   req_id_t r_prio;
   req_id_t w_other;

   assign w_other = other_req(r_prio);

   always_comb begin
      grant = '0;
      if (!rst) begin
         if (valid[r_prio]) begin
            grant[r_prio] = 1'b1;
         end else if (valid[w_other]) begin
            grant[w_other] = 1'b1;
         end
      end
   end

   // The requester that just transferred yields priority to the other one.
   always_ff @(posedge clk0) begin
      if (rst) begin
         r_prio <= 1'b0;
      end else if (|grant) begin
         r_prio <= grant[0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_rw_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw_port_arbiter
// Brief    : Round-robin sequencer for one RW port of a single-port SRAM macro.
// Revision : 1.0
// ============================================================================
module sram_rw_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                          clk0,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_dout,
   output logic                          csb0,
   output logic                          web0,
   output logic [ADDR_WIDTH-1:0]         addr0,
   output logic [DATA_WIDTH-1:0]         din0,
   input  logic [DATA_WIDTH-1:0]         dout0
);

   logic [NUM_REQ-1:0] w_grant;
   logic               w_xfer;
   req_id_t            w_id;
   op_e                w_op;
   pipe_entry_t        w_entry;
   pipe_entry_t        r_stage1;
   pipe_entry_t        r_stage2;

   rr_arb2 u_arb (
      .clk0  (clk0),
      .rst   (rst),
      .valid (req_valid),
      .grant (w_grant)
   );

   assign req_ready = w_grant;
   assign w_xfer    = |w_grant;
   assign w_id      = w_grant[1];
   assign w_op      = op_e'(req_we[w_id]);

   always_comb begin
      w_entry       = '0;
      w_entry.valid = w_xfer;
      w_entry.rd    = (w_op == OP_READ);
      w_entry.id    = w_id;
   end

   // Macro inputs are registered here and sampled again by the macro one edge later.
   always_ff @(posedge clk0) begin
      if (rst) begin
         csb0 <= 1'b1;
         web0 <= 1'b1;
         addr0 <= '0;
         din0 <= '0;
      end else if (w_xfer) begin
         csb0 <= 1'b0;
         web0 <= (w_op == OP_READ);
         addr0 <= req_addr[w_id*ADDR_WIDTH +: ADDR_WIDTH];
         din0 <= req_din[w_id*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         csb0 <= 1'b1;
         web0 <= 1'b1;
      end
   end

   always_ff @(posedge clk0) begin
      if (rst) begin
         r_stage1   <= '0;
         r_stage2   <= '0;
         resp_valid <= '0;
         resp_dout  <= '0;
      end else begin
         r_stage1   <= w_entry;
         r_stage2   <= r_stage1;
         resp_valid <= '0;
         if (r_stage2.valid && r_stage2.rd) begin
            resp_valid[r_stage2.id] <= 1'b1;
            resp_dout               <= dout0;
         end
      end
   end

endmodule
`default_nettype wire
